fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the PC value loaded on reset.
REQ-002 Port clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 Port rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 Port next_pc  in  64  SHALL be the selected next address from the PC-select mux (pc_plus4 or branch target).
REQ-005 Port flush  in  1  SHALL be the taken-branch redirect; next_pc carries the target.
REQ-006 Port stall  in  1  SHALL be the decode stall; IF/ID must hold.
REQ-007 Port pc_plus4  out  64  SHALL be pc + 4, fed back to the mux.
REQ-008 Ports imem_req out 1, imem_addr out 64, imem_ready in 1 SHALL form the request handshake; a request transfers when imem_req & imem_ready.
REQ-009 Ports imem_rvalid in 1, imem_rdata in 32 SHALL form the response; exactly one response per transferred request, no backpressure.
REQ-010 Ports if_id_valid out 1, if_id_pc out 64, if_id_instr out 32, if_id_fault out 1 SHALL form the IF/ID pipeline register.

Function
REQ-011 pc_plus4 SHALL be combinational pc + 4 modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
REQ-012 FSM states SHALL be REQ, WAIT, HOLD, DRAIN; reset state REQ.
REQ-013 REQ: imem_req=1, imem_addr=pc; transfer -> WAIT; no transfer -> stay; imem_rvalid ignored.
REQ-014 WAIT/HOLD/DRAIN: imem_req=0.
REQ-015 WAIT, imem_rvalid & !stall: IF/ID <= {1, pc, imem_rdata}; pc <= next_pc; -> REQ.
REQ-016 WAIT, imem_rvalid & stall: response stored in 1-entry hold buffer; -> HOLD; IF/ID unchanged.
REQ-017 HOLD & !stall: IF/ID <= buffer; pc <= next_pc; -> REQ.
REQ-018 DRAIN: next imem_rvalid discarded; -> REQ.
REQ-019 When not stalled and no instruction loads this cycle, if_id_valid SHALL clear to 0 (bubble).
REQ-020 stall SHALL freeze IF/ID and pc.
REQ-021 flush SHALL take priority over stall and rvalid: next cycle if_id_valid=0, hold buffer cleared, pc <= next_pc.
REQ-022 flush next state: REQ with transfer -> DRAIN; REQ without -> REQ; WAIT with rvalid -> REQ (data dropped); WAIT without rvalid -> DRAIN; HOLD -> REQ; DRAIN with rvalid -> REQ, else DRAIN.
REQ-023 Minimum latency SHALL be 2 cycles from REQ entry to IF/ID load; peak throughput one instruction per 2 cycles.

Reset
REQ-024 rst SHALL override all inputs: pc=RESET_PC, state=REQ, hold buffer empty, if_id_valid=0, if_id_pc=0, if_id_instr=0, if_id_fault=0.
REQ-025 Reset mid-operation SHALL abandon any outstanding request; imem is reset by the same rst.

Configuration
REQ-026 With FETCH_ALIGN_CHECK_EN defined: pc[1:0]!=0 in REQ SHALL suppress imem_req and load IF/ID {valid=1, pc, instr=0, fault=1} on the next unstalled cycle, then pc <= next_pc.
REQ-027 Without FETCH_ALIGN_CHECK_EN: imem_addr[1:0] SHALL be forced to 0 and if_id_fault tied 0.

Structure
REQ-028 Package fetch_pkg SHALL hold the FSM state enum, ADDR_W=64, INSTR_W=32, PC_INC=4.
REQ-029 The hold buffer SHALL be a sub-module fetch_hold_buf (1 entry, valid/pc/instr, load/clear/read).

Verification
REQ-030 Reset, RESET_PC=0, imem_ready=1, 1-cycle response rdata=0x8B020020 -> imem_addr=0 at cycle 1; IF/ID {1,0,0x8B020020} at cycle 3; next imem_addr=4.
REQ-031 Response arrives with stall=1 for 3 cycles -> IF/ID unchanged, state HOLD; load on first stall=0 cycle.
REQ-032 flush in WAIT with next_pc=0x100, response 1 cycle later -> response dropped, if_id_valid=0, next imem_addr=0x100.
REQ-033 pc=0xFFFF_FFFF_FFFF_FFFC -> pc_plus4=0; fetch continues at 0.
REQ-034 flush & stall same cycle -> flush wins: if_id_valid=0 next cycle.
REQ-035 FETCH_ALIGN_CHECK_EN, next_pc=0x102 -> no imem_req; IF/ID {1,0x102,0,fault=1}.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
//   ADDR_W        - program counter / instruction address width
//   INSTR_W       - instruction word width
//   PC_INC        - sequential PC increment
//   fetch_state_e - fetch FSM states (REQ, WAIT, HOLD, DRAIN)
package fetch_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,  // request to imem is being offered at pc
    ST_WAIT  = 2'd1,  // request accepted, waiting for its response
    ST_HOLD  = 2'd2,  // response parked in hold buffer while decode stalls
    ST_DRAIN = 2'd3   // flushed request still in flight, discard its response
  } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry parking buffer for an instruction response that
// arrives while decode is stalled.
//   clk, rst            - clock, synchronous active-high reset
//   load                - capture load_pc/load_instr, mark valid
//   clear               - drop the entry (flush), highest priority after rst
//   read                - entry consumed by IF/ID this cycle, mark empty
//   load_pc, load_instr - entry payload to capture
//   valid, rd_pc, rd_instr - current entry
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic               read,
  input  logic [ADDR_W-1:0]  load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  output logic               valid,
  output logic [ADDR_W-1:0]  rd_pc,
  output logic [INSTR_W-1:0] rd_instr
);

  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch can be inferred.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      instr_d = load_instr;
    end else if (read) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  // NOTE: the payload is deliberately left unreset; valid_q alone decides
  // whether it means anything, which keeps reset fan-out off the data path.
  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    instr_q <= instr_d;
  end

  assign valid    = valid_q;
  assign rd_pc    = pc_q;
  assign rd_instr = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding-request instruction fetch stage feeding the
// IF/ID pipeline register.
//   clk, rst                 - clock, synchronous active-high reset
//   next_pc                  - next address from the PC-select mux
//   flush                    - taken-branch redirect (next_pc is the target)
//   stall                    - decode stall, IF/ID and pc hold
//   pc_plus4                 - pc + 4, fed back to the PC-select mux
//   imem_req/addr/ready      - request handshake (transfer on req & ready)
//   imem_rvalid/rdata        - response, one per transferred request
//   if_id_valid/pc/instr/fault - IF/ID pipeline register
// Optional build macro FETCH_ALIGN_CHECK_EN: a misaligned pc suppresses the
// imem request and delivers a faulting bubble-instruction instead. Without
// it the low address bits are forced to zero and if_id_fault is always 0.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  next_pc,
  input  logic               flush,
  input  logic               stall,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_id_valid,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_fault
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               if_id_valid_q, if_id_valid_d;
  logic [ADDR_W-1:0]  if_id_pc_q, if_id_pc_d;
  logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
  logic               xfer;

  logic               hb_load, hb_clear, hb_read, hb_valid;
  logic [ADDR_W-1:0]  hb_pc;
  logic [INSTR_W-1:0] hb_instr;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned;
  logic if_id_fault_q, if_id_fault_d;

  assign misaligned  = (pc_q[1:0] != 2'b00);
  assign imem_req    = (state_q == ST_REQ) && !misaligned;
  assign imem_addr   = pc_q;
  assign if_id_fault = if_id_fault_q;
`else
  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = {pc_q[ADDR_W-1:2], 2'b00};
  assign if_id_fault = 1'b0;
`endif

  assign xfer     = imem_req & imem_ready;
  assign pc_plus4 = pc_q + PC_INC;

  fetch_hold_buf u_hold_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (hb_load),
    .clear      (hb_clear),
    .read       (hb_read),
    .load_pc    (pc_q),
    .load_instr (imem_rdata),
    .valid      (hb_valid),
    .rd_pc      (hb_pc),
    .rd_instr   (hb_instr)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
`ifdef FETCH_ALIGN_CHECK_EN
    if_id_fault_d = if_id_fault_q;
`endif
    hb_load  = 1'b0;
    hb_clear = 1'b0;
    hb_read  = 1'b0;

    if (flush) begin
      // Redirect wins over stall and rvalid; an in-flight request for the
      // old path must still be drained because imem answers every transfer.
      if_id_valid_d = 1'b0;
      hb_clear      = 1'b1;
      pc_d          = next_pc;
      unique case (state_q)
        ST_REQ:   state_d = xfer ? ST_DRAIN : ST_REQ;
        ST_WAIT:  state_d = imem_rvalid ? ST_REQ : ST_DRAIN;
        ST_HOLD:  state_d = ST_REQ;
        ST_DRAIN: state_d = imem_rvalid ? ST_REQ : ST_DRAIN;
        default:  state_d = ST_REQ;
      endcase
    end else begin
      // Unstalled cycle with nothing to load inserts a bubble.
      if (!stall) if_id_valid_d = 1'b0;

      unique case (state_q)
        ST_REQ: begin
          if (xfer) state_d = ST_WAIT;
`ifdef FETCH_ALIGN_CHECK_EN
          if (misaligned && !stall) begin
            if_id_valid_d = 1'b1;
            if_id_pc_d    = pc_q;
            if_id_instr_d = '0;
            if_id_fault_d = 1'b1;
            pc_d          = next_pc;
          end
`endif
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (!stall) begin
              if_id_valid_d = 1'b1;
              if_id_pc_d    = pc_q;
              if_id_instr_d = imem_rdata;
`ifdef FETCH_ALIGN_CHECK_EN
              if_id_fault_d = 1'b0;
`endif
              pc_d          = next_pc;
              state_d       = ST_REQ;
            end else begin
              hb_load = 1'b1;
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            if_id_valid_d = hb_valid;
            if_id_pc_d    = hb_pc;
            if_id_instr_d = hb_instr;
`ifdef FETCH_ALIGN_CHECK_EN
            if_id_fault_d = 1'b0;
`endif
            hb_read       = 1'b1;
            pc_d          = next_pc;
            state_d       = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (imem_rvalid) state_d = ST_REQ;
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) if_id_fault_q <= 1'b0;
    else     if_id_fault_q <= if_id_fault_d;
  end
`endif

  assign if_id_valid = if_id_valid_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table for the documented fetch scenarios,
// a hand-written alignment sequence, then randomized traffic compared
// against a transaction-level model of the fetch stage.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] next_pc;
  logic        flush, stall;
  logic [63:0] pc_plus4;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_fault;

  int n_vec = 0;
  int n_err = 0;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  fetch_unit #(.RESET_PC(64'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .next_pc     (next_pc),
    .flush       (flush),
    .stall       (stall),
    .pc_plus4    (pc_plus4),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_fault (if_id_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        flush, stall, ready, rvalid;
    logic [31:0] rdata;
    logic [63:0] next_pc;
    logic        exp_req;
    logic [63:0] exp_addr, exp_plus4;
    logic        exp_valid;
    logic [63:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  function automatic vec_t v(input logic f, s, r, rv, input logic [31:0] d,
                             input logic [63:0] np, input logic er,
                             input logic [63:0] ea, ep4, input logic ev,
                             input logic [63:0] epc, input logic [31:0] ei);
    vec_t x;
    x.flush = f; x.stall = s; x.ready = r; x.rvalid = rv; x.rdata = d;
    x.next_pc = np; x.exp_req = er; x.exp_addr = ea; x.exp_plus4 = ep4;
    x.exp_valid = ev; x.exp_pc = epc; x.exp_instr = ei;
    return x;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; next_pc = '0;
    @(posedge clk); #1;
    check("rst if_id_valid", if_id_valid, 1'b0);
    check("rst if_id_pc", if_id_pc, 64'h0);
    check("rst if_id_instr", if_id_instr, 32'h0);
    check("rst if_id_fault", if_id_fault, 1'b0);
    check("rst pc_plus4", pc_plus4, 64'h4);
    check("rst imem_req", imem_req, 1'b1);
    check("rst imem_addr", imem_addr, 64'h0);
  endtask

  task automatic apply_vec(input vec_t x, input int i);
    @(negedge clk);
    rst = 1'b0; flush = x.flush; stall = x.stall; imem_ready = x.ready;
    imem_rvalid = x.rvalid; imem_rdata = x.rdata; next_pc = x.next_pc;
    #1;
    check($sformatf("v%0d imem_req", i), imem_req, x.exp_req);
    if (x.exp_req) check($sformatf("v%0d imem_addr", i), imem_addr, x.exp_addr);
    check($sformatf("v%0d pc_plus4", i), pc_plus4, x.exp_plus4);
    @(posedge clk); #1;
    check($sformatf("v%0d if_id_valid", i), if_id_valid, x.exp_valid);
    check($sformatf("v%0d if_id_pc", i), if_id_pc, x.exp_pc);
    check($sformatf("v%0d if_id_instr", i), if_id_instr, x.exp_instr);
    check($sformatf("v%0d if_id_fault", i), if_id_fault, 1'b0);
  endtask

  // Transaction-level reference: the fetch stage is described only by
  // whether a request is in flight, whether its answer is stale, and a queue
  // of parked answers.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } held_t;

  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_instr;
  logic        m_valid, m_fault, m_out, m_drop;
  held_t       m_held[$];
  int          lat;

  task automatic model_reset();
    m_pc = 64'h0; m_ipc = '0; m_instr = '0; m_valid = 1'b0; m_fault = 1'b0;
    m_out = 1'b0; m_drop = 1'b0; m_held.delete(); lat = 0;
  endtask

  task automatic random_phase(input int cycles);
    logic        do_rst, exp_req, xfer, mis;
    logic [63:0] tgt;
    held_t       h;
    model_reset();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check("rnd if_id_valid", if_id_valid, m_valid);
      check("rnd if_id_pc", if_id_pc, m_ipc);
      check("rnd if_id_instr", if_id_instr, m_instr);
      check("rnd if_id_fault", if_id_fault, m_fault);

      do_rst = ($urandom_range(0, 249) == 0);
      tgt = {$urandom, $urandom};
      tgt[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF8;
      rst         = do_rst;
      flush       = ($urandom_range(0, 7) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      imem_ready  = 1'($urandom_range(0, 1));
      imem_rvalid = m_out && (lat == 0);
      imem_rdata  = $urandom;
      next_pc     = flush ? tgt : m_pc + 64'd4;
      #1;
      mis     = ALIGN_CHK && (m_pc[1:0] != 2'b00);
      exp_req = !m_out && (m_held.size() == 0) && !mis;
      check("rnd imem_req", imem_req, exp_req);
      if (exp_req) check("rnd imem_addr", imem_addr, {m_pc[63:2], 2'b00});
      check("rnd pc_plus4", pc_plus4, m_pc + 64'd4);
      xfer = exp_req && imem_ready;

      if (do_rst) begin
        model_reset();
      end else if (flush) begin
        m_valid = 1'b0;
        m_held.delete();
        m_pc = next_pc;
        if (imem_rvalid) m_out = 1'b0;
        else if (m_out) m_drop = 1'b1;
        if (xfer) begin m_out = 1'b1; m_drop = 1'b1; lat = $urandom_range(0, 2); end
        else if (m_out && lat > 0) lat--;
      end else begin
        if (imem_rvalid) begin
          m_out = 1'b0;
          if (m_drop) begin
            m_drop = 1'b0;
            if (!stall) m_valid = 1'b0;
          end else if (!stall) begin
            m_valid = 1'b1; m_ipc = m_pc; m_instr = imem_rdata; m_fault = 1'b0;
            m_pc = next_pc;
          end else begin
            m_held.push_back('{pc: m_pc, instr: imem_rdata});
          end
        end else if (m_held.size() != 0 && !stall) begin
          h = m_held.pop_front();
          m_valid = 1'b1; m_ipc = h.pc; m_instr = h.instr; m_fault = 1'b0;
          m_pc = next_pc;
        end else if (!m_out && m_held.size() == 0 && mis && !stall) begin
          m_valid = 1'b1; m_ipc = m_pc; m_instr = '0; m_fault = 1'b1;
          m_pc = next_pc;
        end else if (!stall) begin
          m_valid = 1'b0;
        end
        if (xfer) begin m_out = 1'b1; m_drop = 1'b0; lat = $urandom_range(0, 2); end
        else if (m_out && lat > 0) lat--;
      end
      @(posedge clk);
    end
  endtask

  initial begin
    vec_t vecs[$];
    //                  fl st rd rv rdata         next_pc               req addr                  plus4                 val if_id_pc              if_id_instr
    vecs.push_back(v(0, 0, 1, 0, 32'h0,        64'h4,               1, 64'h0,               64'h4,               0, 64'h0,               32'h0));
    vecs.push_back(v(0, 0, 0, 1, 32'h8B020020, 64'h4,               0, 64'h0,               64'h4,               1, 64'h0,               32'h8B020020));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,        64'h8,               1, 64'h4,               64'h8,               0, 64'h0,               32'h8B020020));
    vecs.push_back(v(0, 0, 1, 0, 32'h0,        64'h8,               1, 64'h4,               64'h8,               0, 64'h0,               32'h8B020020));
    vecs.push_back(v(0, 1, 0, 1, 32'h11111111, 64'h8,               0, 64'h0,               64'h8,               0, 64'h0,               32'h8B020020));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        64'h8,               0, 64'h0,               64'h8,               0, 64'h0,               32'h8B020020));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        64'h8,               0, 64'h0,               64'h8,               0, 64'h0,               32'h8B020020));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,        64'h8,               0, 64'h0,               64'h8,               1, 64'h4,               32'h11111111));
    vecs.push_back(v(0, 0, 1, 0, 32'h0,        64'hC,               1, 64'h8,               64'hC,               0, 64'h4,               32'h11111111));
    vecs.push_back(v(1, 0, 0, 0, 32'h0,        64'h100,             0, 64'h0,               64'hC,               0, 64'h4,               32'h11111111));
    vecs.push_back(v(0, 0, 0, 1, 32'hDEADBEEF, 64'h104,             0, 64'h0,               64'h104,             0, 64'h4,               32'h11111111));
    vecs.push_back(v(0, 0, 1, 0, 32'h0,        64'h104,             1, 64'h100,             64'h104,             0, 64'h4,               32'h11111111));
    vecs.push_back(v(1, 1, 0, 1, 32'h22222222, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0,           64'h104,             0, 64'h4,               32'h11111111));
    vecs.push_back(v(0, 0, 1, 0, 32'h0,        64'h0,               1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0,          0, 64'h4,               32'h11111111));
    vecs.push_back(v(0, 0, 0, 1, 32'h33333333, 64'h0,               0, 64'h0,               64'h0,               1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h33333333));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,        64'h4,               1, 64'h0,               64'h4,               0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h33333333));
    vecs.push_back(v(1, 0, 1, 0, 32'h0,        64'h200,             1, 64'h0,               64'h4,               0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h33333333));
    vecs.push_back(v(0, 0, 0, 1, 32'h44444444, 64'h204,             0, 64'h0,               64'h204,             0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h33333333));
    vecs.push_back(v(0, 0, 1, 0, 32'h0,        64'h204,             1, 64'h200,             64'h204,             0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h33333333));
    vecs.push_back(v(0, 0, 0, 1, 32'h55555555, 64'h204,             0, 64'h0,               64'h204,             1, 64'h200,             32'h55555555));

    do_reset();
    foreach (vecs[i]) apply_vec(vecs[i], i);

    // Redirect to a misaligned target (state REQ, pc 0x204, no transfer).
    @(negedge clk);
    flush = 1'b1; stall = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    next_pc = 64'h102;
    #1;
    check("mis redirect imem_addr", imem_addr, 64'h204);
    @(negedge clk);
    flush = 1'b0; imem_ready = 1'b1; next_pc = 64'h104;
    #1;
    check("mis pc_plus4", pc_plus4, 64'h106);
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis imem_req", imem_req, 1'b0);
    @(posedge clk); #1;
    check("mis if_id_valid", if_id_valid, 1'b1);
    check("mis if_id_pc", if_id_pc, 64'h102);
    check("mis if_id_instr", if_id_instr, 32'h0);
    check("mis if_id_fault", if_id_fault, 1'b1);
    @(negedge clk); #1;
    check("mis next imem_req", imem_req, 1'b1);
    check("mis next imem_addr", imem_addr, 64'h104);
`else
    check("mis imem_req", imem_req, 1'b1);
    check("mis imem_addr", imem_addr, 64'h100);
    @(negedge clk);
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h66666666;
    @(posedge clk); #1;
    check("mis if_id_valid", if_id_valid, 1'b1);
    check("mis if_id_pc", if_id_pc, 64'h102);
    check("mis if_id_instr", if_id_instr, 32'h66666666);
    check("mis if_id_fault", if_id_fault, 1'b0);
`endif

    do_reset();
    random_phase(4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
